// File: rtl/ckpt_pkg.sv
// Shared encodings for the checkpoint scoreboard: per-entry status,
// termination cause and FSM state.
package ckpt_pkg;

   typedef enum logic [1:0] {
      ST_UNTESTED = 2'd0,
      ST_PASS     = 2'd1,
      ST_FAIL     = 2'd2,
      ST_MISSED   = 2'd3
   } ckpt_status_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_HALT    = 2'd1,
      CAUSE_TIMEOUT = 2'd2,
      CAUSE_FAIL    = 2'd3
   } ckpt_cause_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } ckpt_state_e;

endpackage

// File: rtl/ckpt_table.sv
// Checkpoint storage: (instruction count, answer) table with a write port and
// one indexed read, plus the per-entry 2-bit status array.
module ckpt_table
   import ckpt_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int NUM_TEST  = 56,
   parameter int IDX_W     = $clog2(NUM_TEST)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tbl_we_i,
   input  logic [IDX_W-1:0]     tbl_addr_i,
   input  logic [WORD_SIZE-1:0] tbl_inst_i,
   input  logic [WORD_SIZE-1:0] tbl_ans_i,
   input  logic [IDX_W-1:0]     rd_idx_i,
   output logic [WORD_SIZE-1:0] rd_inst_o,
   output logic [WORD_SIZE-1:0] rd_ans_o,
   input  logic                 stat_clr_i,
   input  logic                 stat_we_i,
   input  ckpt_status_e         stat_val_i,
   input  logic [IDX_W-1:0]     stat_addr_i,
   output logic [1:0]           stat_data_o
);

   localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(NUM_TEST);

   logic [WORD_SIZE-1:0] inst_q [NUM_TEST];
   logic [WORD_SIZE-1:0] ans_q  [NUM_TEST];
   ckpt_status_e         status_q [NUM_TEST];

   // Table contents deliberately survive reset so a rerun needs no reload.
   always_ff @(posedge clk) begin
      if (tbl_we_i && ({1'b0, tbl_addr_i} < DEPTH)) begin
         inst_q[tbl_addr_i] <= tbl_inst_i;
         ans_q[tbl_addr_i]  <= tbl_ans_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || stat_clr_i) begin
         for (int unsigned i = 0; i < NUM_TEST; i++) begin
            status_q[i] <= ST_UNTESTED;
         end
      end else if (stat_we_i) begin
         status_q[rd_idx_i] <= stat_val_i;
      end
   end

   assign rd_inst_o   = inst_q[rd_idx_i];
   assign rd_ans_o    = ans_q[rd_idx_i];
   assign stat_data_o = ({1'b0, stat_addr_i} < DEPTH) ? status_q[stat_addr_i] : ST_UNTESTED;

endmodule

// File: rtl/checkpoint_monitor.sv
// Checkpoint scoreboard beside the CPU: resolves one table entry per RUN cycle.
// Define CKPT_CONTINUE_ON_FAIL_EN to keep running after a FAIL verdict.
module checkpoint_monitor
   import ckpt_pkg::*;
#(
   parameter  int WORD_SIZE  = 16,
   parameter  int NUM_TEST   = 56,
   parameter  int CYC_W      = 16,
   parameter  int MAX_CYCLES = 10000,
   localparam int IDX_W      = $clog2(NUM_TEST)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WORD_SIZE-1:0] num_inst,
   input  logic [WORD_SIZE-1:0] output_port,
   input  logic                 is_halted,
   input  logic                 tbl_we,
   input  logic [IDX_W-1:0]     tbl_addr,
   input  logic [WORD_SIZE-1:0] tbl_inst,
   input  logic [WORD_SIZE-1:0] tbl_ans,
   input  logic [IDX_W-1:0]     stat_addr,
   output logic [1:0]           stat_data,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           done_cause,
   output logic [IDX_W:0]       pass_cnt,
   output logic [IDX_W:0]       fail_cnt,
   output logic [IDX_W:0]       miss_cnt,
   output logic                 all_pass,
   output logic [CYC_W-1:0]     num_clock
);

   localparam int             CNT_W      = IDX_W + 1;
   localparam logic [IDX_W:0] DEPTH      = CNT_W'(NUM_TEST);
   localparam logic [IDX_W:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CYC_W-1:0] TIMEOUT_AT = CYC_W'(MAX_CYCLES - 1);
   localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);

   ckpt_state_e      state_q, state_d;
   ckpt_cause_e      cause_q, cause_d;
   logic [IDX_W:0]   ptr_q, ptr_d;
   logic [IDX_W:0]   pass_q, pass_d, fail_q, fail_d, miss_q, miss_d;
   logic [CYC_W-1:0] clk_q, clk_d;

   logic                 ptr_valid, hit, skip, fail_now, fail_stop, wr_en;
   logic                 stat_clr, stat_we;
   ckpt_status_e         stat_val;
   logic [IDX_W-1:0]     rd_idx;
   logic [WORD_SIZE-1:0] rd_inst, rd_ans;
   ckpt_cause_e          end_cause;

   assign ptr_valid = ptr_q < DEPTH;
   assign rd_idx    = ptr_valid ? ptr_q[IDX_W-1:0] : '0;
   assign hit       = ptr_valid && (num_inst == rd_inst);
   assign skip      = ptr_valid && (num_inst > rd_inst);

   ckpt_table #(
      .WORD_SIZE (WORD_SIZE),
      .NUM_TEST  (NUM_TEST),
      .IDX_W     (IDX_W)
   ) u_table (
      .clk         (clk),
      .reset       (reset),
      .tbl_we_i    (wr_en),
      .tbl_addr_i  (tbl_addr),
      .tbl_inst_i  (tbl_inst),
      .tbl_ans_i   (tbl_ans),
      .rd_idx_i    (rd_idx),
      .rd_inst_o   (rd_inst),
      .rd_ans_o    (rd_ans),
      .stat_clr_i  (stat_clr),
      .stat_we_i   (stat_we),
      .stat_val_i  (stat_val),
      .stat_addr_i (stat_addr),
      .stat_data_o (stat_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cause_q <= CAUSE_NONE;
         ptr_q   <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         miss_q  <= '0;
         clk_q   <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         ptr_q   <= ptr_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         miss_q  <= miss_d;
         clk_q   <= clk_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      ptr_d     = ptr_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      miss_d    = miss_q;
      clk_d     = clk_q;
      wr_en     = 1'b0;
      stat_clr  = 1'b0;
      stat_we   = 1'b0;
      stat_val  = ST_UNTESTED;
      fail_now  = 1'b0;
      fail_stop = 1'b0;
      end_cause = CAUSE_NONE;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            wr_en = (state_q == S_IDLE) && tbl_we;
            if (start) begin
               state_d  = S_RUN;
               cause_d  = CAUSE_NONE;
               ptr_d    = '0;
               pass_d   = '0;
               fail_d   = '0;
               miss_d   = '0;
               clk_d    = '0;
               stat_clr = 1'b1;
            end
         end

         S_RUN: begin
            if (hit) begin
               stat_we = 1'b1;
               ptr_d   = ptr_q + CNT_ONE;
               if (output_port == rd_ans) begin
                  stat_val = ST_PASS;
                  pass_d   = pass_q + CNT_ONE;
               end else begin
                  stat_val = ST_FAIL;
                  fail_d   = fail_q + CNT_ONE;
                  fail_now = 1'b1;
               end
            end else if (skip) begin
               stat_we  = 1'b1;
               stat_val = ST_MISSED;
               ptr_d    = ptr_q + CNT_ONE;
               miss_d   = miss_q + CNT_ONE;
            end

`ifdef CKPT_CONTINUE_ON_FAIL_EN
            fail_stop = 1'b0;
            // A FAIL anywhere in the run, including this cycle, overrides halt/timeout.
            end_cause = (fail_d != '0) ? CAUSE_FAIL
                      : (is_halted ? CAUSE_HALT : CAUSE_TIMEOUT);
`else
            fail_stop = fail_now;
            end_cause = is_halted ? CAUSE_HALT : CAUSE_TIMEOUT;
`endif

            if (fail_stop) begin
               state_d = S_DONE;
               cause_d = CAUSE_FAIL;
            end else if (is_halted || (clk_q == TIMEOUT_AT)) begin
               state_d = S_DONE;
               cause_d = end_cause;
            end else if (clk_q != '1) begin
               clk_d = clk_q + CYC_ONE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign done_cause = cause_q;
   assign pass_cnt   = pass_q;
   assign fail_cnt   = fail_q;
   assign miss_cnt   = miss_q;
   assign all_pass   = done && (pass_q == DEPTH);
   assign num_clock  = clk_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Directed bench for checkpoint_monitor with a 3-entry table and a 20-cycle timeout.
module tb_checkpoint_monitor;

   localparam int WS   = 16;
   localparam int NT   = 3;
   localparam int CW   = 16;
   localparam int MAXC = 20;
   localparam int IW   = $clog2(NT);

   logic          clk = 1'b0;
   logic          reset, start, is_halted, tbl_we;
   logic [WS-1:0] num_inst, output_port, tbl_inst, tbl_ans;
   logic [IW-1:0] tbl_addr, stat_addr;
   logic [1:0]    stat_data, done_cause;
   logic          busy, done, all_pass;
   logic [IW:0]   pass_cnt, fail_cnt, miss_cnt;
   logic [CW-1:0] num_clock;

   int n_checks = 0;
   int n_fail   = 0;

   checkpoint_monitor #(
      .WORD_SIZE  (WS),
      .NUM_TEST   (NT),
      .CYC_W      (CW),
      .MAX_CYCLES (MAXC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_inst    (num_inst),
      .output_port (output_port),
      .is_halted   (is_halted),
      .tbl_we      (tbl_we),
      .tbl_addr    (tbl_addr),
      .tbl_inst    (tbl_inst),
      .tbl_ans     (tbl_ans),
      .stat_addr   (stat_addr),
      .stat_data   (stat_data),
      .busy        (busy),
      .done        (done),
      .done_cause  (done_cause),
      .pass_cnt    (pass_cnt),
      .fail_cnt    (fail_cnt),
      .miss_cnt    (miss_cnt),
      .all_pass    (all_pass),
      .num_clock   (num_clock)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int inst, input int port);
      num_inst    = WS'(inst);
      output_port = WS'(port);
      tick();
   endtask

   task automatic load(input int addr, input int inst, input int ans);
      tbl_we   = 1'b1;
      tbl_addr = IW'(addr);
      tbl_inst = WS'(inst);
      tbl_ans  = WS'(ans);
      tick();
      tbl_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic halt();
      is_halted = 1'b1;
      tick();
      is_halted = 1'b0;
   endtask

   task automatic stat_chk(input string tag, input int idx, input int exp);
      stat_addr = IW'(idx);
      #1;
      check_eq(tag, 32'(stat_data), 32'(exp));
   endtask

   // Entries (3,0),(5,0),(0xB,1): correct answers at checkpoints, 0 elsewhere.
   task automatic good_ramp();
      for (int i = 0; i <= 11; i++) drive(i, (i == 11) ? 1 : 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; is_halted = 1'b0; tbl_we = 1'b0;
      num_inst = '0; output_port = '0; tbl_addr = '0; tbl_inst = '0; tbl_ans = '0;
      stat_addr = '0;
      tick(); tick();
      reset = 1'b0;

      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_cause", 32'(done_cause), 0);
      check_eq("rst_pass", 32'(pass_cnt), 0);
      check_eq("rst_nclk", 32'(num_clock), 0);
      stat_chk("rst_stat0", 0, 0);

      // All-pass run ending in halt
      load(0, 3, 0); load(1, 5, 0); load(2, 11, 1);
      pulse_start();
      check_eq("t1_busy", 32'(busy), 1);
      good_ramp();
      check_eq("t1_pre_done", 32'(done), 0);
      check_eq("t1_pass_pre", 32'(pass_cnt), 3);
      halt();
      check_eq("t1_done", 32'(done), 1);
      check_eq("t1_cause", 32'(done_cause), 1);
      check_eq("t1_pass", 32'(pass_cnt), 3);
      check_eq("t1_allpass", 32'(all_pass), 1);
      check_eq("t1_nclk", 32'(num_clock), 12);
      stat_chk("t1_stat2", 2, 1);

      // Wrong answer at checkpoint 7
      do_reset();
      load(1, 7, 3);
      pulse_start();
      for (int i = 0; i <= 6; i++) drive(i, 0);
      check_eq("t2_pre_done", 32'(done), 0);
      drive(7, 2);
      stat_chk("t2_stat1", 1, 2);
      check_eq("t2_fail", 32'(fail_cnt), 1);
      check_eq("t2_pass", 32'(pass_cnt), 1);
`ifdef CKPT_CONTINUE_ON_FAIL_EN
      check_eq("t2_still_busy", 32'(busy), 1);
      drive(8, 0);
      halt();
`endif
      check_eq("t2_done", 32'(done), 1);
      check_eq("t2_cause", 32'(done_cause), 3);
      check_eq("t2_allpass", 32'(all_pass), 0);

      // Write in DONE must be ignored; start from DONE clears results
      load(1, 5, 0);
      pulse_start();
      check_eq("t2r_busy", 32'(busy), 1);
      check_eq("t2r_pass_clr", 32'(pass_cnt), 0);
      stat_chk("t2r_stat1_clr", 1, 0);
      for (int i = 0; i <= 6; i++) drive(i, 0);
      stat_chk("t2r_stat1_untested", 1, 0);
      check_eq("t2r_miss", 32'(miss_cnt), 0);

      // Skipped checkpoint; table write coincident with start
      do_reset();
      tbl_we = 1'b1; tbl_addr = IW'(1); tbl_inst = WS'(5); tbl_ans = '0;
      start = 1'b1;
      tick();
      tbl_we = 1'b0; start = 1'b0;
      for (int i = 0; i <= 4; i++) drive(i, 0);
      drive(6, 0);
      stat_chk("t3_stat1", 1, 3);
      check_eq("t3_miss", 32'(miss_cnt), 1);
      for (int i = 7; i <= 10; i++) drive(i, 0);
      drive(11, 1);
      stat_chk("t3_stat2", 2, 1);
      halt();
      check_eq("t3_cause", 32'(done_cause), 1);
      check_eq("t3_pass", 32'(pass_cnt), 2);
      check_eq("t3_allpass", 32'(all_pass), 0);

      // Stall at a checkpoint: single verdict; start in RUN ignored
      do_reset();
      pulse_start();
      for (int i = 0; i <= 2; i++) drive(i, 0);
      drive(3, 0);
      drive(3, 5);
      start = 1'b1;
      drive(3, 6);
      start = 1'b0;
      drive(3, 7);
      drive(3, 8);
      check_eq("t4_pass", 32'(pass_cnt), 1);
      check_eq("t4_fail", 32'(fail_cnt), 0);
      check_eq("t4_busy", 32'(busy), 1);
      stat_chk("t4_stat0", 0, 1);
      halt();
      check_eq("t4_cause", 32'(done_cause), 1);

      // Timeout
      do_reset();
      pulse_start();
      for (int i = 0; i < 19; i++) drive(0, 0);
      check_eq("t5_pre_done", 32'(done), 0);
      check_eq("t5_pre_nclk", 32'(num_clock), 19);
      drive(0, 0);
      check_eq("t5_done", 32'(done), 1);
      check_eq("t5_cause", 32'(done_cause), 2);
      check_eq("t5_nclk", 32'(num_clock), 19);

      // Reset mid-RUN, then rerun with the retained table
      do_reset();
      pulse_start();
      for (int i = 0; i <= 3; i++) drive(i, 0);
      check_eq("t6_pass_pre", 32'(pass_cnt), 1);
      do_reset();
      check_eq("t6_busy", 32'(busy), 0);
      check_eq("t6_pass", 32'(pass_cnt), 0);
      check_eq("t6_nclk", 32'(num_clock), 0);
      check_eq("t6_cause", 32'(done_cause), 0);
      stat_chk("t6_stat0", 0, 0);
      pulse_start();
      good_ramp();
      halt();
      check_eq("t6_rerun_pass", 32'(pass_cnt), 3);
      check_eq("t6_rerun_allpass", 32'(all_pass), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/checkpoint_monitor.md
# checkpoint_monitor

Synthesizable, parametrised checkpoint scoreboard for the 16-bit pipelined CPU. It watches the retired-instruction count and the `WWD` output port, and compares `output_port` against a loadable table of (instruction count, expected answer) pairs. It records a per-entry verdict and produces pass/fail/miss summaries, a cycle count and a termination cause. It sits beside `cpu` in both simulation and FPGA builds, replacing the testbench-only checking loop.

## Interface
Parameters:
- `WORD_SIZE`, 16: width of `num_inst`, `output_port` and table fields.
- `NUM_TEST`, 56: number of table entries.
- `CYC_W`, 16: width of the cycle counter.
- `MAX_CYCLES`, 10000: timeout limit in RUN cycles.
- `IDX_W` (localparam): `$clog2(NUM_TEST)`.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse; clears results and enters RUN.
- `num_inst`  in  WORD_SIZE: retired-instruction count from `cpu`.
- `output_port`  in  WORD_SIZE: `WWD` value from `cpu`.
- `is_halted`  in  1: CPU halted.
- `tbl_we`  in  1: table write enable (honoured only in IDLE).
- `tbl_addr`  in  IDX_W: table write index.
- `tbl_inst`  in  WORD_SIZE: checkpoint instruction count.
- `tbl_ans`  in  WORD_SIZE: expected `output_port` value.
- `stat_addr`  in  IDX_W: status readback index.
- `stat_data`  out  2: status of entry `stat_addr`; combinational read.
- `busy`  out  1: state == RUN.
- `done`  out  1: state == DONE.
- `done_cause`  out  2: 0 none, 1 halt, 2 timeout, 3 fail.
- `pass_cnt`, `fail_cnt`, `miss_cnt`  out  IDX_W+1 each: verdict counters.
- `all_pass`  out  1: `done && pass_cnt == NUM_TEST`.
- `num_clock`  out  CYC_W: RUN cycles elapsed.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:**
  - Table writes are accepted.
  - `start` clears all statuses to UNTESTED, zeroes the counters, `ptr` and `num_clock`, sets `done_cause` to 0 and goes to RUN.
- **RUN:** each cycle, the entry at `ptr` (entries ascending by `tbl_inst`) is evaluated against the sampled `num_inst`:
  - If `num_inst == tbl_inst[ptr]`: the entry becomes PASS if `output_port == tbl_ans[ptr]`, otherwise FAIL. The matching counter increments and `ptr` advances.
  - If `num_inst > tbl_inst[ptr]`: the checkpoint was skipped. The entry becomes MISSED, `miss_cnt` increments and `ptr` advances. At most one entry is resolved per cycle.
  - If `ptr == NUM_TEST`: there is no comparison. The monitor waits for halt or timeout.
  - Each entry is evaluated once only. Stalls that hold `num_inst` constant do not re-check the entry.
- **RUN → DONE:** the first of fail (see Configuration), `is_halted` or `num_clock == MAX_CYCLES-1`. The cause is latched with priority fail > halt > timeout. The entry evaluated in the terminating cycle is always recorded.
- **DONE:** outputs hold. `start` restarts as from IDLE. Table writes are ignored.
- **Status encoding:** 0 UNTESTED, 1 PASS, 2 FAIL, 3 MISSED. "No result" count = `NUM_TEST - pass_cnt - fail_cnt - miss_cnt`.
- Non-ascending table entries resolve as MISSED; no error is flagged.

## Timing
- Inputs are sampled on posedge. Status, counters and state update on that same edge, so they are visible one cycle after the sampled values.
- `done` rises one cycle after the terminating sample.
- `num_clock` increments once per RUN cycle and saturates at all-ones.
- **Reset values:**
  - state IDLE; `busy`, `done`, `all_pass` 0.
  - `done_cause` 0; all counters 0; `num_clock` 0.
  - all statuses UNTESTED.
  - The inst/ans table contents are not reset.
- **Reset mid-RUN:** the monitor returns to IDLE on the next edge with the values above.
- A `start` pulse in RUN is ignored.
- A `tbl_we` and `start` arriving in the same IDLE cycle: the write is performed and RUN is entered.

## Configuration
- `CKPT_CONTINUE_ON_FAIL_EN` undefined: the first FAIL terminates RUN with `done_cause` 3.
- `CKPT_CONTINUE_ON_FAIL_EN` defined: FAIL is recorded and RUN continues. `done_cause` becomes 3 at halt or timeout if `fail_cnt != 0`.

## Structure
- The package `ckpt_pkg` holds:
  - status codes UNTESTED/PASS/FAIL/MISSED.
  - `done_cause` codes.
  - FSM state encoding.
- The sub-module `ckpt_table` contains the inst/ans storage (write port plus indexed read at `ptr`) and the 2-bit status array (clear, write at `ptr`, read at `stat_addr`). The FSM, counters and compare logic stay in `checkpoint_monitor`.

## Test plan
- Load entries (3,0x0000), (5,0x0000), (0xB,0x0001); drive `num_inst` 0..0xB in steps of 1 with correct values, then `is_halted` → `pass_cnt` 3, `done_cause` 1, `all_pass` 1.
- Entry (7,0x0003) with `output_port` 0x0002 at `num_inst` 7, macro undefined → entry FAIL, `done` one cycle later, `done_cause` 3. With the macro defined, RUN continues until halt.
- `num_inst` jumps 4→6 past entry (5,x) → entry 5 MISSED, `miss_cnt` 1, next entry still evaluated.
- Hold `num_inst` at 3 for 5 cycles with `output_port` changing → single verdict from the first cycle.
- Never halt, `MAX_CYCLES` 20 → `done` after 20 RUN cycles, `done_cause` 2, `num_clock` 19.
- Assert `reset` mid-RUN, then `start` → counters 0, statuses UNTESTED, table intact, rerun passes.
